// File: rtl/display_mux_pkg.sv
// Shared types and defaults for the multiplexed 7-segment display producer.
// Contents: nibble_t digit type, default digit count / prescaler, index width helper.
package display_pkg;

  typedef logic [3:0] nibble_t;

  localparam int unsigned N_DIG_DEF = 4;
  localparam int unsigned DIV_DEF   = 27000;

  // Width of a counter over n values, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_mux_divisor_tick.sv
// Refresh-slot prescaler: counts 0..DIV-1 and raises tick for the cycle in
// which the count sits at DIV-1.
// Ports:
//   clk   in  system clock, rising edge
//   rst_n in  asynchronous active-low reset
//   tick  out 1-cycle pulse, registered, every DIV cycles
module divisor_tick
  import display_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned      CNT_W = clog2_min1(DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] PRE   = CNT_W'(DIV - 2);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_tick;
  logic             w_tick_nxt;

  // Tick is registered one count early so it is high exactly while r_cnt == DIV-1.
  always_comb begin
    w_cnt_nxt  = (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
    w_tick_nxt = (r_cnt == PRE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tick <= w_tick_nxt;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/display_mux.sv
// Scans an N_DIG-digit hex value onto a single shared 7-segment decoder.
// Captured values are double-buffered and only become visible at a frame
// boundary (the tick that ends the last digit slot), so a frame never tears.
// Optional feature: define DISPLAY_MUX_BLANK_EN for leading-zero blanking.
// Ports:
//   clk     in  system clock, rising edge
//   rst_n   in  asynchronous active-low reset
//   dato    in  4*N_DIG value, nibble k -> digit k (digit 0 least significant)
//   cargar  in  1-cycle strobe: capture dato
//   ocupado out a captured value waits for the next frame boundary
//   palabra out current digit nibble for the decoder
//   anodo   out one-hot active-low digit enable
module display_mux
  import display_pkg::*;
#(
  parameter int unsigned N_DIG = N_DIG_DEF,
  parameter int unsigned DIV   = DIV_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4*N_DIG-1:0] dato,
  input  logic               cargar,
  output logic               ocupado,
  output logic [3:0]         palabra,
  output logic [N_DIG-1:0]   anodo
);

  localparam int unsigned      IDX_W    = clog2_min1(N_DIG);
  localparam int unsigned      DW       = 4 * N_DIG;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIG - 1);
  localparam logic [N_DIG-1:0] AN_RST   = ~N_DIG'(1);

  logic             w_tick;
  logic             w_boundary;

  logic [IDX_W-1:0] r_idx,     w_idx_nxt;
  logic [DW-1:0]    r_activo,  w_activo_nxt;
  logic [DW-1:0]    r_pend,    w_pend_nxt;
  logic             r_ocupado, w_ocupado_nxt;
  nibble_t          r_palabra, w_palabra_nxt;
  logic [N_DIG-1:0] r_anodo,   w_anodo_nxt;

  nibble_t          w_nib;
  logic [N_DIG-1:0] w_onehot;
`ifdef DISPLAY_MUX_BLANK_EN
  logic             w_upper_zero;
`endif

  divisor_tick #(.DIV(DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  // Next-state: scan index, frame-boundary buffer swap, and slot outputs.
  always_comb begin
    w_idx_nxt     = r_idx;
    w_activo_nxt  = r_activo;
    w_pend_nxt    = r_pend;
    w_ocupado_nxt = r_ocupado;
    w_palabra_nxt = r_palabra;
    w_anodo_nxt   = r_anodo;
    w_nib         = '0;
    w_onehot      = '0;
`ifdef DISPLAY_MUX_BLANK_EN
    w_upper_zero  = 1'b1;
`endif

    w_boundary = w_tick && (r_idx == LAST_IDX);

    if (w_tick) begin
      w_idx_nxt = w_boundary ? '0 : r_idx + IDX_W'(1);
    end

    // A strobe landing on the boundary bypasses the pending buffer entirely.
    if (w_boundary) begin
      if (cargar) begin
        w_activo_nxt = dato;
      end else if (r_ocupado) begin
        w_activo_nxt = r_pend;
      end
      w_ocupado_nxt = 1'b0;
    end else if (cargar) begin
      w_pend_nxt    = dato;
      w_ocupado_nxt = 1'b1;
    end

    // Slot outputs come from the post-swap value so digit 0 of a new frame is already fresh.
    for (int unsigned k = 0; k < N_DIG; k++) begin
      if (IDX_W'(k) == w_idx_nxt) begin
        w_nib       = w_activo_nxt[4*k +: 4];
        w_onehot[k] = 1'b1;
      end
`ifdef DISPLAY_MUX_BLANK_EN
      if ((IDX_W'(k) >= w_idx_nxt) && (w_activo_nxt[4*k +: 4] != 4'h0)) begin
        w_upper_zero = 1'b0;
      end
`endif
    end

    if (w_tick) begin
      w_palabra_nxt = w_nib;
`ifdef DISPLAY_MUX_BLANK_EN
      // Digit 0 is never blanked so an all-zero value still shows one "0".
      w_anodo_nxt = ((w_idx_nxt != '0) && w_upper_zero) ? '1 : ~w_onehot;
`else
      w_anodo_nxt = ~w_onehot;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_activo  <= '0;
      r_pend    <= '0;
      r_ocupado <= 1'b0;
      r_palabra <= '0;
      r_anodo   <= AN_RST;
    end else begin
      r_idx     <= w_idx_nxt;
      r_activo  <= w_activo_nxt;
      r_pend    <= w_pend_nxt;
      r_ocupado <= w_ocupado_nxt;
      r_palabra <= w_palabra_nxt;
      r_anodo   <= w_anodo_nxt;
    end
  end

  assign ocupado = r_ocupado;
  assign palabra = r_palabra;
  assign anodo   = r_anodo;

endmodule

// File: tb/tb_display_mux.sv
// Self-checking bench for display_mux with N_DIG=4, DIV=4.
// Reference model works from the cycle count since reset: slot = (e/DIV)%N_DIG,
// boundary = last cycle of each DIV*N_DIG frame.
module tb_display_mux;

  localparam int unsigned N  = 4;
  localparam int unsigned D  = 4;
  localparam int unsigned FR = N * D;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        cargar = 1'b0;
  logic [15:0] dato   = '0;
  logic        ocupado;
  logic [3:0]  palabra;
  logic [3:0]  anodo;

  always #5 clk = ~clk;

  display_mux #(.N_DIG(N), .DIV(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .dato    (dato),
    .cargar  (cargar),
    .ocupado (ocupado),
    .palabra (palabra),
    .anodo   (anodo)
  );

  int checks = 0;
  int errors = 0;

  // Model state: e = cycles elapsed since reset release.
  int unsigned e = 0;
  logic [15:0] m_act  = '0;
  logic [15:0] m_pend = '0;
  logic        m_occ  = 1'b0;

  typedef struct {
    int unsigned off;
    logic [15:0] d;
    logic        occ;
  } vec_t;

  vec_t tbl [5];
  vec_t tv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, e);
    end
  endtask

  function automatic logic [3:0] exp_an(input int unsigned s, input logic [15:0] v);
    logic [3:0] one;
`ifdef DISPLAY_MUX_BLANK_EN
    if (s != 0 && (v >> (4 * s)) == 16'h0) return 4'hF;
`endif
    one = 4'b0001 << s;
    return ~one;
  endfunction

  task automatic model_check();
    int unsigned idx;
    logic [15:0] sh;
    idx = (e / D) % N;
    sh  = m_act >> (4 * idx);
    chk("ocupado", 32'(ocupado), 32'(m_occ));
    chk("palabra", 32'(palabra), 32'(sh[3:0]));
    chk("anodo",   32'(anodo),   32'(exp_an(idx, m_act)));
  endtask

  // One clock: drive at negedge, update model at posedge, check at next negedge.
  task automatic cyc(input logic c, input logic [15:0] d);
    cargar = c;
    dato   = d;
    @(posedge clk);
    if ((e % FR) == FR - 1) begin
      m_act = c ? d : (m_occ ? m_pend : m_act);
      m_occ = 1'b0;
    end else if (c) begin
      m_pend = d;
      m_occ  = 1'b1;
    end
    e++;
    @(negedge clk);
    cargar = 1'b0;
    model_check();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    chk("rst_anodo",   32'(anodo),   32'(4'b1110));
    chk("rst_palabra", 32'(palabra), 32'(4'h0));
    chk("rst_ocupado", 32'(ocupado), 32'(1'b0));
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    e      = 0;
    m_act  = '0;
    m_pend = '0;
    m_occ  = 1'b0;
    model_check();
  endtask

  task automatic align();
    while ((e % FR) != 0) cyc(1'b0, 16'h0);
  endtask

  // Checks a whole frame against a literal expected value.
  task automatic check_frame(input string name, input logic [15:0] v);
    logic [15:0] sh;
    for (int unsigned s = 0; s < FR; s++) begin
      sh = v >> (4 * (s / D));
      chk(name, 32'(palabra), 32'(sh[3:0]));
      chk("anodo_frame", 32'(anodo), 32'(exp_an(s / D, v)));
      cyc(1'b0, 16'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{off: 5,  d: 16'h1234, occ: 1'b1};
    tbl[1] = '{off: 15, d: 16'hBEEF, occ: 1'b0};
    tbl[2] = '{off: 0,  d: 16'h0042, occ: 1'b1};
    tbl[3] = '{off: 15, d: 16'h0000, occ: 1'b0};
    tbl[4] = '{off: 14, d: 16'hCAFE, occ: 1'b1};

    @(negedge clk);
    reset_dut();

    // Table: load at a given frame offset, ocupado profile, then next frame contents.
    for (int i = 0; i < 5; i++) begin
      tv = tbl[i];
      align();
      for (int unsigned c = 0; c < FR; c++) begin
        cyc(c == tv.off, tv.d);
        chk("ocupado_tbl", 32'(ocupado),
            32'(tv.occ && (c >= tv.off) && (c < FR - 1)));
      end
      check_frame("palabra_tbl", tv.d);
    end

    // Two loads in one frame: the later one wins.
    align();
    for (int unsigned c = 0; c < FR; c++) begin
      cyc((c == 2) || (c == 9), (c == 2) ? 16'hAAAA : 16'h5555);
      if (c == FR - 2) chk("ocupado_pre_bnd", 32'(ocupado), 32'(1'b1));
    end
    check_frame("palabra_last_wins", 16'h5555);

    // Reset mid-frame in slot 2 with a pending value.
    align();
    for (int unsigned c = 0; c < 9; c++) cyc(c == 8, 16'h9876);
    chk("occ_before_rst", 32'(ocupado), 32'(1'b1));
    chk("anodo_slot2",    32'(anodo),   32'(4'b1011));
    reset_dut();
    for (int unsigned c = 0; c < 2 * FR; c++) cyc(1'b0, 16'h0);
    chk("palabra_after_rst", 32'(palabra), 32'(4'h0));
    chk("ocupado_after_rst", 32'(ocupado), 32'(1'b0));

    // Random loads against the model.
    for (int i = 0; i < 500; i++) begin
      cyc($urandom_range(0, 5) == 0, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
